rgb_to_yuv_m1: RTL
==================

RGB_TO_YUV_M1 -- requirements
Module: rgb_to_yuv_m1

Interface
REQ-001 SHALL have parameter Y_OFFSET, default 18'd0, which is the base word address of the Y plane.
REQ-002 SHALL have parameter U_OFFSET, default 18'd38400, which is the base word address of the U plane.
REQ-003 SHALL have parameter V_OFFSET, default 18'd57600, which is the base word address of the V plane.
REQ-004 SHALL have parameter RGB_OFFSET, default 18'd146944, which is the base word address of the packed RGB source.
REQ-005 SHALL have parameter PIXEL_COUNT, default 76800, which is the pixel count per frame; it must be a multiple of 4.
REQ-006 SHALL have port CLOCK_50_I: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port Reset: input, 1 bit, synchronous, active-high reset.
REQ-008 SHALL have port M1E_START: input, 1 bit, start request, sampled in IDLE only.
REQ-009 SHALL have port SRAM_read_data: input, 16 bits, SRAM read bus.
REQ-010 SHALL have port SRAM_ADDRESS_m1e: output, 18 bits, registered SRAM word address.
REQ-011 SHALL have port SRAM_write_data_m1e: output, 16 bits, registered write data.
REQ-012 SHALL have port SRAM_we_n_m1e: output, 1 bit, registered active-low write enable.
REQ-013 SHALL have port M1E_END: output, 1 bit, one-cycle done pulse.

Function
REQ-014 SHALL model SRAM reads as follows: data for an address on SRAM_ADDRESS_m1e is valid on SRAM_read_data exactly 2 cycles later; a write occurs on every cycle with SRAM_we_n_m1e=0.
REQ-015 SHALL read the RGB source in this packing: word 3k={R2k,G2k}, 3k+1={B2k,R2k+1}, 3k+2={G2k+1,B2k+1}, with the high byte first.
REQ-016 SHALL process the frame in groups of 4 pixels (g = 0 .. PIXEL_COUNT/4-1): read RGB words RGB_OFFSET+6g .. +6g+5, in ascending order.
REQ-017 SHALL write, per group, in this order: Y_OFFSET+2g={Y0,Y1}, Y_OFFSET+2g+1={Y2,Y3}, U_OFFSET+g={Ua,Ub}, V_OFFSET+g={Va,Vb}, where a is the chroma of pixel pair 0/1 and b is the chroma of pixel pair 2/3.
REQ-018 SHALL compute Y=(16843R+33030G+6423B+1081344)>>>16.
REQ-019 SHALL compute U=(-9699R-19071G+28770B+8421376)>>>16.
REQ-020 SHALL compute V=(28770R-24117G-4653B+8421376)>>>16.
REQ-021 SHALL use signed 32-bit arithmetic for the conversions in REQ-018 to REQ-020, with an arithmetic right shift.
REQ-022 SHALL clip every Y/U/V result to [0,255]: negative results become 0 and results above 255 become 255.
REQ-023 SHALL use at most four signed 32x32 multipliers, time-shared across the conversion.
REQ-024 SHALL have states IDLE, FETCH, CALC, WRITE and DONE.
REQ-025 SHALL move IDLE->FETCH on M1E_START=1.
REQ-026 SHALL move FETCH->CALC after the 6th read datum is captured.
REQ-027 SHALL move CALC->WRITE when all results for the group are ready.
REQ-028 SHALL move WRITE->FETCH after the 4th write, unless the group is the last one, in which case WRITE->DONE.
REQ-029 SHALL move DONE->IDLE unconditionally.
REQ-030 SHALL take at most 24 cycles per group, measured from the first address of the group to the last write.
REQ-031 SHALL hold SRAM_we_n_m1e=0 only on the 4 write cycles of each group; the address and data buses SHALL be valid on those same cycles.
REQ-032 SHALL assert M1E_END for exactly one cycle, in DONE, after the final V write.
REQ-033 SHALL ignore M1E_START while not in IDLE.
REQ-034 SHALL start a new frame from group 0 if M1E_START=1 in IDLE after a completed frame.
REQ-035 SHALL issue its final writes to Y_OFFSET+PIXEL_COUNT/2-1, U_OFFSET+PIXEL_COUNT/4-1 and V_OFFSET+PIXEL_COUNT/4-1; no address beyond these SHALL be written.

Reset
REQ-036 SHALL, on Reset=1 at a rising edge, set: state=IDLE, SRAM_we_n_m1e=1, SRAM_ADDRESS_m1e=0, SRAM_write_data_m1e=0, M1E_END=0, group counter=0, and all data registers=0.
REQ-037 SHALL treat a reset asserted mid-frame as abandoning the frame: no further writes occur, and the next M1E_START restarts at group 0.

Configuration
REQ-038 SHALL, when macro RGB2YUV_CHROMA_AVG_EN is defined, compute the pair chroma as (Ceven+Codd+1)>>1, using the clipped 8-bit per-pixel values with a 9-bit intermediate.
REQ-039 SHALL, when RGB2YUV_CHROMA_AVG_EN is undefined, use the even-pixel chroma only: no odd-pixel U/V is computed, and the cycle budget in REQ-030 still applies.

Verification
REQ-040 SHALL be verified with all pixels RGB=(0,0,0) -> every Y word=16'h1010, and every U and V word=16'h8080.
REQ-041 SHALL be verified with all pixels RGB=(255,255,255) -> every Y word=16'hEBEB, and every U and V word=16'h8080.
REQ-042 SHALL be verified with group 0 pixels red,blue,red,blue (255,0,0 / 0,0,255) -> Y words 16'h5229, 16'h5229; with the macro defined, U=16'hA5A5 and V=16'hAFAF; with the macro undefined, U=16'h5A5A and V=16'hF0F0.
REQ-043 SHALL be verified with PIXEL_COUNT=8 and random RGB -> exactly 4 Y, 2 U and 2 V writes, matching a golden model, followed by one M1E_END pulse.
REQ-044 SHALL be verified with M1E_START pulsed again mid-frame -> the pulse is ignored; the write count and M1E_END behaviour are unchanged.
REQ-045 SHALL be verified with Reset=1 at cycle 100 of a frame -> on the next edge SRAM_we_n_m1e=1 and state=IDLE; a subsequent M1E_START first reads RGB_OFFSET.

Source files
------------

// File: rtl/rgb_to_yuv_m1.sv
// rgb_to_yuv_m1: frame-wide RGB->YUV converter over a 2-cycle-latency SRAM, one 4-pixel group at a time.
// Define RGB2YUV_CHROMA_AVG_EN to average even/odd chroma per pixel pair; otherwise the even pixel's chroma is used.
module rgb_to_yuv_m1 #(
  parameter logic [17:0] Y_OFFSET = 18'd0,
  parameter logic [17:0] U_OFFSET = 18'd38400,
  parameter logic [17:0] V_OFFSET = 18'd57600,
  parameter logic [17:0] RGB_OFFSET = 18'd146944,
  parameter int PIXEL_COUNT = 76800
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        M1E_START,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_ADDRESS_m1e,
  output logic [15:0] SRAM_write_data_m1e,
  output logic        SRAM_we_n_m1e,
  output logic        M1E_END
);
  typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;
`ifdef RGB2YUV_CHROMA_AVG_EN
  localparam logic [3:0] CALC_LAST = 4'd11;
`else
  localparam logic [3:0] CALC_LAST = 4'd7;
`endif
  localparam logic [17:0] LAST_G = 18'(PIXEL_COUNT / 4 - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [17:0] grp, rd_ptr;
  logic [15:0] w [6];
  logic [7:0] y [4];
  logic [7:0] u [4];
  logic [7:0] v [4];
  logic [1:0] pix, kind, wk;
  logic [15:0] a0, a1, a2;
  logic [7:0] pr, pg, pb, res, ua, ub, va, vb;
  logic signed [31:0] cr, cg, cb, co, acc, sh;
  logic last_grp, calc_done, rd_go, wr_go;
  always_ff @(posedge CLOCK_50_I)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = M1E_START ? FETCH : IDLE;
      FETCH: state_n = cnt == 4'd7 ? CALC : FETCH;
      CALC:  state_n = calc_done ? WRITE : CALC;
      WRITE: state_n = cnt == 4'd3 ? (last_grp ? DONE : FETCH) : WRITE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    M1E_END = state == DONE;
    last_grp = grp == LAST_G;
    calc_done = state == CALC && cnt == CALC_LAST;
    rd_go = (state == FETCH && cnt < 4'd5) || (state == WRITE && cnt == 4'd3 && !last_grp);
    wr_go = calc_done || (state == WRITE && cnt != 4'd3);
    wk = state == CALC ? 2'd0 : cnt[1:0] + 2'd1;
  end
  // One output value per CALC cycle: Y for all four pixels first, then chroma.
`ifdef RGB2YUV_CHROMA_AVG_EN
  logic [2:0] j;
  always_comb begin
    j = 3'(cnt - 4'd4);
    pix = cnt < 4'd4 ? cnt[1:0] : {j[2], j[0]};
    kind = cnt < 4'd4 ? 2'd0 : j[1] ? 2'd2 : 2'd1;
    ua = 8'((9'(u[0]) + 9'(u[1]) + 9'd1) >> 1);
    ub = 8'((9'(u[2]) + 9'(u[3]) + 9'd1) >> 1);
    va = 8'((9'(v[0]) + 9'(v[1]) + 9'd1) >> 1);
    vb = 8'((9'(v[2]) + 9'(v[3]) + 9'd1) >> 1);
  end
`else
  always_comb begin
    pix = cnt[2] ? {cnt[1], 1'b0} : cnt[1:0];
    kind = cnt[2] ? (cnt[0] ? 2'd2 : 2'd1) : 2'd0;
    ua = u[0];
    ub = u[2];
    va = v[0];
    vb = v[2];
  end
`endif
  always_comb begin
    a0 = pix[1] ? w[3] : w[0];
    a1 = pix[1] ? w[4] : w[1];
    a2 = pix[1] ? w[5] : w[2];
    pr = pix[0] ? a1[7:0] : a0[15:8];
    pg = pix[0] ? a2[15:8] : a0[7:0];
    pb = pix[0] ? a2[7:0] : a1[15:8];
    cr = kind == 2'd0 ? 32'sd16843 : kind == 2'd1 ? -32'sd9699 : 32'sd28770;
    cg = kind == 2'd0 ? 32'sd33030 : kind == 2'd1 ? -32'sd19071 : -32'sd24117;
    cb = kind == 2'd0 ? 32'sd6423 : kind == 2'd1 ? 32'sd28770 : -32'sd4653;
    co = kind == 2'd0 ? 32'sd1081344 : 32'sd8421376;
    acc = cr * $signed({24'd0, pr}) + cg * $signed({24'd0, pg}) + cb * $signed({24'd0, pb}) + co;
    sh = acc >>> 16;
    res = sh < 0 ? 8'd0 : sh > 32'sd255 ? 8'd255 : sh[7:0];
  end
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      cnt <= 4'd0;
      grp <= 18'd0;
      rd_ptr <= 18'd0;
      SRAM_ADDRESS_m1e <= 18'd0;
      SRAM_write_data_m1e <= 16'd0;
      SRAM_we_n_m1e <= 1'b1;
      for (int i = 0; i < 6; i++) w[i] <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        y[i] <= 8'd0;
        u[i] <= 8'd0;
        v[i] <= 8'd0;
      end
    end else begin
      cnt <= state_n != state ? 4'd0 : cnt + 4'd1;
      SRAM_we_n_m1e <= !wr_go;
      if (state == IDLE && M1E_START) begin
        grp <= 18'd0;
        SRAM_ADDRESS_m1e <= RGB_OFFSET;
        rd_ptr <= RGB_OFFSET + 18'd1;
      end else if (rd_go) begin
        SRAM_ADDRESS_m1e <= rd_ptr;
        rd_ptr <= rd_ptr + 18'd1;
      end else if (wr_go) begin
        SRAM_ADDRESS_m1e <= wk[1] ? (wk[0] ? V_OFFSET : U_OFFSET) + grp : Y_OFFSET + {grp[16:0], wk[0]};
        SRAM_write_data_m1e <= wk == 2'd0 ? {y[0], y[1]} : wk == 2'd1 ? {y[2], y[3]} : wk == 2'd2 ? {ua, ub} : {va, vb};
      end
      if (state == WRITE && cnt == 4'd3) grp <= grp + 18'd1;
      // Word k is addressed in FETCH cycle k and arrives two cycles later.
      if (state == FETCH && cnt >= 4'd2) w[3'(cnt - 4'd2)] <= SRAM_read_data;
      if (state == CALC) begin
        if (kind == 2'd0) y[pix] <= res;
        else if (kind == 2'd1) u[pix] <= res;
        else v[pix] <= res;
      end
    end
  end
endmodule
